// File: rtl/float_point_normalizer_pkg.sv
// Shared definitions for the post-add normalise/round stage: format widths,
// rounding mode codes and the controller state encoding.
package float_point_normalizer_pkg;

    localparam int SP_EXPONENT_WIDTH = 8;
    localparam int SP_FRACTION_WIDTH = 23;
    localparam int DP_EXPONENT_WIDTH = 11;
    localparam int DP_FRACTION_WIDTH = 52;

    localparam int ROUND_CHOP = 0;
    localparam int ROUND_RNE  = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_LEFT_NORM = 3'd2,
        ST_ROUND     = 3'd3,
        ST_DONE      = 3'd4
    } norm_state_e;

endpackage

// File: rtl/float_point_normalizer_leading_zero_counter.sv
// Counts leading zeros of the SHIFT_STEP-bit window just below the carry bit,
// saturating at SHIFT_STEP when the whole window is zero.
module float_point_leading_zero_counter #(
    parameter int SHIFT_STEP = 8
) (
    input  logic [SHIFT_STEP-1:0]              window_in,
    output logic [$clog2(SHIFT_STEP+1)-1:0]    count_out
);

    localparam int CW = $clog2(SHIFT_STEP + 1);

    // Scanning upward lets the highest set bit win without a found flag.
    always_comb begin
        count_out = CW'(SHIFT_STEP);
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (window_in[i]) begin
                count_out = CW'(SHIFT_STEP - 1 - i);
            end
        end
    end

endmodule

// File: rtl/float_point_normalizer.sv
// Normalises, rounds and packs the raw sum from float_point_adder, presenting
// the result under a valid/ack handshake.
module float_point_normalizer
    import float_point_normalizer_pkg::*;
#(
    parameter int EXPONENT_WIDTH = DP_EXPONENT_WIDTH,
    parameter int FRACTION_WIDTH = DP_FRACTION_WIDTH,
    parameter int GUARD_WIDTH    = 3,
    parameter int SHIFT_STEP     = 8,
    parameter int ROUND_MODE     = ROUND_RNE,
    localparam int MANTISSA_WIDTH = FRACTION_WIDTH + 2 + GUARD_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      sum_valid_in,
    input  logic                      sum_sign_in,
    input  logic [EXPONENT_WIDTH-1:0] sum_exponent_in,
    input  logic [MANTISSA_WIDTH-1:0] sum_mantissa_in,
    output logic                      issue_ack_out,
    output logic                      result_valid_out,
    output logic                      result_sign_out,
    output logic [EXPONENT_WIDTH-1:0] result_exponent_out,
    output logic [FRACTION_WIDTH-1:0] result_fraction_out,
    output logic                      result_overflow_out,
    output logic                      result_underflow_out,
    input  logic                      result_ack_in
);

    localparam int EW = EXPONENT_WIDTH;
    localparam int FW = FRACTION_WIDTH;
    localparam int GW = GUARD_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
    localparam int CW = $clog2(SHIFT_STEP + 1);

    norm_state_e   state_q, state_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [MW-1:0] mant_q, mant_d;
    logic          subnormal_q, subnormal_d;
    logic          nonzero_q, nonzero_d;

    logic          res_sign_q, res_sign_d;
    logic [EW-1:0] res_exp_q, res_exp_d;
    logic [FW-1:0] res_frac_q, res_frac_d;
    logic          res_ovf_q, res_ovf_d;
    logic          res_unf_q, res_unf_d;

    logic [CW-1:0] lz_count;
    logic [EW-1:0] exp_inc;
    logic [EW-1:0] exp_room;
    logic [EW-1:0] shift_amt;
    logic [MW-1:0] mant_shl;
    logic [EW-1:0] exp_shl;

    logic          guard_bit;
    logic          sticky_bit;
    logic          round_up;
    logic [FW+1:0] sig_rnd;
    logic [EW-1:0] rnd_exp;
    logic [FW-1:0] rnd_frac;
    logic          rnd_ovf;

    float_point_leading_zero_counter #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_lzc (
        .window_in (mant_q[MW-2 -: SHIFT_STEP]),
        .count_out (lz_count)
    );

    // Left shifts stop at exponent 1 so a subnormal keeps its true scale.
    assign exp_inc   = exp_q + EW'(1);
    assign exp_room  = (exp_q > EW'(1)) ? exp_q - EW'(1) : '0;
    assign shift_amt = (exp_room < EW'(lz_count)) ? exp_room : EW'(lz_count);
    assign mant_shl  = mant_q << shift_amt;
    assign exp_shl   = exp_q - shift_amt;

    assign guard_bit  = mant_q[GW-1];
    assign sticky_bit = |mant_q[GW-2:0];
    assign round_up   = (ROUND_MODE == ROUND_RNE) && guard_bit && (sticky_bit || mant_q[GW]);
    assign sig_rnd    = {1'b0, mant_q[MW-2:GW]} + {{(FW+1){1'b0}}, round_up};

    always_comb begin
        rnd_exp  = exp_q;
        rnd_frac = sig_rnd[FW-1:0];
        rnd_ovf  = 1'b0;
        if (sig_rnd[FW+1]) begin
            rnd_exp  = exp_inc;
            rnd_frac = '0;
            rnd_ovf  = &exp_inc;
        end else if (subnormal_q) begin
            rnd_exp = sig_rnd[FW] ? EW'(1) : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        subnormal_d = subnormal_q;
        nonzero_d   = nonzero_q;
        res_sign_d  = res_sign_q;
        res_exp_d   = res_exp_q;
        res_frac_d  = res_frac_q;
        res_ovf_d   = res_ovf_q;
        res_unf_d   = res_unf_q;

        case (state_q)
            ST_IDLE: begin
                if (sum_valid_in) begin
                    sign_d      = sum_sign_in;
                    exp_d       = sum_exponent_in;
                    mant_d      = sum_mantissa_in;
                    nonzero_d   = |sum_mantissa_in;
                    subnormal_d = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                res_sign_d = sign_q;
                res_ovf_d  = 1'b0;
                res_unf_d  = 1'b0;
                if (&exp_q) begin
                    res_exp_d  = exp_q;
                    res_frac_d = mant_q[MW-3:GW];
                    state_d    = ST_DONE;
                end else if (!nonzero_q) begin
                    res_exp_d  = '0;
                    res_frac_d = '0;
                    state_d    = ST_DONE;
                end else if (mant_q[MW-1]) begin
                    // Dropped LSB folds into the sticky position.
                    mant_d = {1'b0, mant_q[MW-1:1]} | {{(MW-1){1'b0}}, mant_q[0]};
                    exp_d  = exp_inc;
                    if (&exp_inc) begin
                        res_exp_d  = exp_inc;
                        res_frac_d = '0;
                        res_ovf_d  = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_ROUND;
                    end
                end else if (mant_q[MW-2]) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_LEFT_NORM;
                end
            end
            ST_LEFT_NORM: begin
                mant_d = mant_shl;
                exp_d  = exp_shl;
                if (mant_shl[MW-2] || exp_shl <= EW'(1)) begin
                    subnormal_d = !mant_shl[MW-2];
                    state_d     = ST_ROUND;
                end
            end
            ST_ROUND: begin
                res_sign_d = sign_q;
                res_exp_d  = rnd_exp;
                res_frac_d = rnd_frac;
                res_ovf_d  = rnd_ovf;
                res_unf_d  = (rnd_exp == '0) && nonzero_q;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (result_ack_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            subnormal_q <= 1'b0;
            nonzero_q   <= 1'b0;
            res_sign_q  <= 1'b0;
            res_exp_q   <= '0;
            res_frac_q  <= '0;
            res_ovf_q   <= 1'b0;
            res_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            subnormal_q <= subnormal_d;
            nonzero_q   <= nonzero_d;
            res_sign_q  <= res_sign_d;
            res_exp_q   <= res_exp_d;
            res_frac_q  <= res_frac_d;
            res_ovf_q   <= res_ovf_d;
            res_unf_q   <= res_unf_d;
        end
    end

    // Gate with reset so the block never advertises readiness while held in reset.
    assign issue_ack_out        = (state_q == ST_IDLE) && !reset_in;
    assign result_valid_out     = (state_q == ST_DONE);
    assign result_sign_out      = res_sign_q;
    assign result_exponent_out  = res_exp_q;
    assign result_fraction_out  = res_frac_q;
    assign result_overflow_out  = res_ovf_q;
    assign result_underflow_out = res_unf_q;

endmodule

// File: tb/tb_float_point_normalizer.sv
// Scoreboard bench: an RNE and a chop instance run in lockstep on the same
// random and directed sums, checked against an arithmetic reference model.
module tb_float_point_normalizer;

    typedef struct {
        logic        s;
        logic [10:0] e;
        logic [51:0] f;
        logic        ov;
        logic        un;
    } res_t;

    typedef struct {
        res_t rne;
        res_t chop;
        int   lat;
        int   cap;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        sum_valid_in = 1'b0;
    logic        sum_sign_in = 1'b0;
    logic [10:0] sum_exponent_in = '0;
    logic [56:0] sum_mantissa_in = '0;
    logic        result_ack_in = 1'b0;

    logic        r_ack, r_valid, r_sign, r_ovf, r_unf;
    logic [10:0] r_exp;
    logic [51:0] r_frac;
    logic        c_ack, c_valid, c_sign, c_ovf, c_unf;
    logic [10:0] c_exp;
    logic [51:0] c_frac;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   force_hold = 1'b0;
    exp_t sb[$];

    float_point_normalizer #(.ROUND_MODE(1)) dut_rne (
        .clk_in (clk_in), .reset_in (reset_in),
        .sum_valid_in (sum_valid_in), .sum_sign_in (sum_sign_in),
        .sum_exponent_in (sum_exponent_in), .sum_mantissa_in (sum_mantissa_in),
        .issue_ack_out (r_ack), .result_valid_out (r_valid),
        .result_sign_out (r_sign), .result_exponent_out (r_exp),
        .result_fraction_out (r_frac), .result_overflow_out (r_ovf),
        .result_underflow_out (r_unf), .result_ack_in (result_ack_in)
    );

    float_point_normalizer #(.ROUND_MODE(0)) dut_chop (
        .clk_in (clk_in), .reset_in (reset_in),
        .sum_valid_in (sum_valid_in), .sum_sign_in (sum_sign_in),
        .sum_exponent_in (sum_exponent_in), .sum_mantissa_in (sum_mantissa_in),
        .issue_ack_out (c_ack), .result_valid_out (c_valid),
        .result_sign_out (c_sign), .result_exponent_out (c_exp),
        .result_fraction_out (c_frac), .result_overflow_out (c_ovf),
        .result_underflow_out (c_unf), .result_ack_in (result_ack_in)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic res_t mk(logic s, logic [10:0] e, logic [51:0] f, logic ov, logic un);
        res_t r;
        r.s = s; r.e = e; r.f = f; r.ov = ov; r.un = un;
        return r;
    endfunction

    // Value-level model: locate the leading one, shift as far as the exponent
    // allows, then round the 53-bit significand with integer arithmetic.
    function automatic res_t model(logic s, logic [10:0] e_in, logic [56:0] m_in,
                                   bit rne, output int lat);
        res_t        r;
        logic [56:0] m;
        logic [53:0] sig;
        int          e, p, need, avail, sh, rem;
        bit          sub;
        r = mk(s, '0, '0, 1'b0, 1'b0);
        m = m_in;
        e = int'(e_in);
        sub = 1'b0;
        lat = 3;
        if (e_in == 11'h7FF) begin
            r.e = e_in; r.f = m_in[54:3]; lat = 2;
            return r;
        end
        if (m_in == '0) begin
            lat = 2;
            return r;
        end
        if (m[56]) begin
            m = (m >> 1) | (m & 57'd1);
            e = e + 1;
            if (e == 2047) begin
                r.e = 11'h7FF; r.ov = 1'b1; lat = 2;
                return r;
            end
        end else if (!m[55]) begin
            p = 0;
            for (int i = 0; i < 55; i++) if (m[i]) p = i;
            need  = 55 - p;
            avail = (e > 1) ? e - 1 : 0;
            sh    = (need < avail) ? need : avail;
            m     = m << sh;
            e     = e - sh;
            lat   = lat + ((sh == 0) ? 1 : (sh + 7) / 8);
            sub   = !m[55];
        end
        sig = {1'b0, m[55:3]};
        rem = int'(m[2:0]);
        if (rne && (rem > 4 || (rem == 4 && sig[0]))) sig = sig + 54'd1;
        if (sig >= (54'd1 << 53)) begin
            sig = '0;
            e = e + 1;
        end else if (sub) begin
            e = (sig >= (54'd1 << 52)) ? 1 : 0;
        end
        r.e  = 11'(e);
        r.f  = sig[51:0];
        r.ov = (e == 2047);
        r.un = (e == 0);
        return r;
    endfunction

    task automatic send(input logic s, input logic [10:0] e, input logic [56:0] m,
                        input bit dir, input res_t xr, input int xlat);
        exp_t x;
        int   w, lat2;
        @(negedge clk_in);
        sum_sign_in = s; sum_exponent_in = e; sum_mantissa_in = m; sum_valid_in = 1'b1;
        w = 0;
        while (!r_ack && w < 200) begin
            @(negedge clk_in);
            w++;
        end
        if (!r_ack) begin
            chk("issue_ack_timeout", 64'(r_ack), 64'(1));
            sum_valid_in = 1'b0;
            return;
        end
        @(posedge clk_in);
        #1;
        sum_valid_in = 1'b0;
        x.rne  = model(s, e, m, 1'b1, x.lat);
        x.chop = model(s, e, m, 1'b0, lat2);
        if (dir) begin
            x.rne = xr;
            x.lat = xlat;
        end
        x.cap = cyc;
        sb.push_back(x);
    endtask

    task automatic quiesce();
        int w;
        w = 0;
        while ((sb.size() != 0 || !r_ack) && w < 500) begin
            @(negedge clk_in);
            w++;
        end
        chk("quiesce_timeout", 64'(sb.size() == 0 && r_ack), 64'(1));
    endtask

    function automatic logic [133:0] outs();
        return {r_valid, r_sign, r_exp, r_frac, r_ovf, r_unf,
                c_valid, c_sign, c_exp, c_frac, c_ovf, c_unf};
    endfunction

    task automatic check_dut(input string tag, input logic s, input logic [10:0] e,
                             input logic [51:0] f, input logic ov, input logic un, input res_t x);
        chk({tag, "_sign_exp_ovf_unf"}, 64'({s, e, ov, un}), 64'({x.s, x.e, x.ov, x.un}));
        chk({tag, "_fraction"}, 64'(f), 64'(x.f));
    endtask

    initial begin : monitor
        exp_t         x;
        logic [133:0] snap;
        bit           stable;
        int           hold;
        forever begin
            @(negedge clk_in);
            if (!reset_in && (r_valid || c_valid)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                end else begin
                    x = sb.pop_front();
                    chk("rne_valid", 64'(r_valid), 64'(1));
                    chk("chop_valid", 64'(c_valid), 64'(1));
                    chk("latency", 64'(cyc - x.cap + 1), 64'(x.lat));
                    chk("issue_ack_while_busy", 64'({r_ack, c_ack}), 64'(0));
                    check_dut("rne", r_sign, r_exp, r_frac, r_ovf, r_unf, x.rne);
                    check_dut("chop", c_sign, c_exp, c_frac, c_ovf, c_unf, x.chop);
                end
                hold = force_hold ? 5 : $urandom_range(0, 3);
                snap = outs();
                stable = 1'b1;
                repeat (hold) begin
                    @(negedge clk_in);
                    if (outs() !== snap) stable = 1'b0;
                end
                if (hold > 0) chk("hold_stable", 64'(stable), 64'(1));
                result_ack_in = 1'b1;
                @(negedge clk_in);
                result_ack_in = 1'b0;
                chk("valid_drop_after_ack", 64'({r_valid, c_valid}), 64'(0));
                chk("idle_after_ack", 64'({r_ack, c_ack}), 64'(3));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] r64;
        logic [56:0] m;
        logic [10:0] e;
        logic        s;
        int          cls, p;
        res_t        nd;
        nd = mk(1'b0, '0, '0, 1'b0, 1'b0);

        #1;
        chk("reset_issue_ack", 64'({r_ack, c_ack}), 64'(0));
        chk("reset_valid", 64'({r_valid, c_valid}), 64'(0));
        chk("reset_result", 64'({r_sign, r_exp, r_ovf, r_unf, c_exp}), 64'(0));
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;

        send(1'b0, 11'h3FF, 57'd1 << 55, 1'b1, mk(1'b0, 11'h3FF, 52'd0, 1'b0, 1'b0), 3);
        send(1'b0, 11'h400, (57'd1 << 56) | 57'd1, 1'b1, mk(1'b0, 11'h401, 52'd0, 1'b0, 1'b0), 3);
        send(1'b0, 11'h7FE, 57'd1 << 56, 1'b1, mk(1'b0, 11'h7FF, 52'd0, 1'b1, 1'b0), 2);
        send(1'b0, 11'h3FF, 57'd1 << 45, 1'b1, mk(1'b0, 11'h3F5, 52'd0, 1'b0, 1'b0), 5);
        send(1'b0, 11'h003, 57'd1 << 40, 1'b1, mk(1'b0, 11'h000, 52'd1 << 39, 1'b0, 1'b1), 4);
        send(1'b0, 11'h3FF, (57'd1 << 55) | (57'd1 << 3) | (57'd1 << 2), 1'b1,
             mk(1'b0, 11'h3FF, 52'd2, 1'b0, 1'b0), 3);
        send(1'b0, 11'h3FF, (57'd1 << 55) | (57'd1 << 2), 1'b1,
             mk(1'b0, 11'h3FF, 52'd0, 1'b0, 1'b0), 3);
        send(1'b1, 11'h000, 57'd0, 1'b1, mk(1'b1, 11'h000, 52'd0, 1'b0, 1'b0), 2);
        send(1'b0, 11'h7FF, 57'd5 << 3, 1'b1, mk(1'b0, 11'h7FF, 52'd5, 1'b0, 1'b0), 2);

        force_hold = 1'b1;
        send(1'b1, 11'h123, (57'd1 << 55) | (57'd7 << 10), 1'b1,
             mk(1'b1, 11'h123, 52'h380, 1'b0, 1'b0), 3);
        send(1'b0, 11'h200, 57'd1 << 55, 1'b1, mk(1'b0, 11'h200, 52'd0, 1'b0, 1'b0), 3);
        force_hold = 1'b0;

        for (int n = 0; n < 300; n++) begin
            r64 = {$urandom, $urandom};
            m   = r64[56:0];
            s   = 1'($urandom_range(0, 1));
            e   = 11'($urandom_range(1, 2046));
            cls = $urandom_range(0, 9);
            case (cls)
                0: e = 11'h7FF;
                1: m = '0;
                2: begin
                    m[56] = 1'b1;
                    if ($urandom_range(0, 3) == 0) e = 11'h7FE;
                end
                3, 4, 5: begin
                    m[56] = 1'b0;
                    m[55] = 1'b1;
                    if ($urandom_range(0, 2) == 0) m[2:0] = 3'b100;
                end
                6, 7, 8: begin
                    p = $urandom_range(0, 54);
                    m = (m & ((57'd1 << p) - 57'd1)) | (57'd1 << p);
                    if ($urandom_range(0, 1) == 1) e = 11'($urandom_range(0, 20));
                end
                default: begin
                    e = 11'h7FE;
                    m = {2'b01, {55{1'b1}}};
                end
            endcase
            send(s, e, m, 1'b0, nd, 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk_in);
        end

        send(1'b0, 11'h3FF, 57'd1 << 55, 1'b1, mk(1'b0, 11'h3FF, 52'd0, 1'b0, 1'b0), 3);
        quiesce();
        @(negedge clk_in);
        sum_sign_in = 1'b0; sum_exponent_in = 11'h3FF; sum_mantissa_in = 57'd1 << 45;
        sum_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        sum_valid_in = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        reset_in = 1'b1;
        #1;
        chk("reset_mid_norm_valid", 64'({r_valid, c_valid}), 64'(0));
        chk("reset_mid_norm_issue_ack", 64'({r_ack, c_ack}), 64'(0));
        chk("reset_mid_norm_result", 64'({r_exp, c_exp}), 64'(0));
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        send(1'b0, 11'h3FF, 57'd1 << 45, 1'b1, mk(1'b0, 11'h3F5, 52'd0, 1'b0, 1'b0), 5);
        quiesce();
        repeat (3) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
